interval_timer_ctrl: RTL and testbench
======================================

# interval_timer_ctrl

Programmable interval-timer controller that sequences a free-running up-counter datapath into start/stop/pause-controlled timing intervals. It adds a prescaler, a latched terminal period, one-shot vs. auto-reload modes and an expiry pulse. It sits between control logic (software-visible registers or an FSM) and any logic needing periodic or one-shot timing events.

## Interface
- WIDTH, 8, width of main counter and period
- PRE_W, 4, width of prescaler and prescale setting
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, asynchronous, active-high
- start  input  1  begin (or restart) an interval; sampled each edge
- stop  input  1  abort interval, return to IDLE
- pause  input  1  level; freezes counting while high in RUN
- mode  input  1  0 = one-shot, 1 = auto-reload; latched on start
- period  input  WIDTH  terminal count P; latched on start
- prescale  input  PRE_W  prescale value S; latched on start; tick every S+1 cycles
- count  output  WIDTH  current counter value
- busy  output  1  high in RUN or PAUSE
- expire  output  1  one-cycle pulse when interval completes
- expire_cnt  output  4  saturating count of expirations since last start

## Operation
- States: IDLE, RUN, PAUSE.
- Reset (async): state=IDLE, count=0, prescaler=0, expire=0, expire_cnt=0, busy=0, latched mode/period/prescale=0.
- Input priority on each edge: stop > start > pause.
- stop (any state): state→IDLE, count=0, prescaler=0, expire=0; expire_cnt holds.
- start (any state, stop low): latch mode/period/prescale, count=0, prescaler=0, expire_cnt=0, state→RUN. A start in RUN/PAUSE restarts the interval.
- RUN, pause high: state→PAUSE; count/prescaler hold. PAUSE, pause low: state→RUN. No tick on the transition edge in either direction.
- RUN, no control event: tick = (prescaler == S_latched).
  - No tick: prescaler+1.
  - Tick, count != P: count+1, prescaler=0.
  - Tick, count == P: expire=1, prescaler=0, expire_cnt+1 (saturates at 15); mode 1: count=0, stay RUN; mode 0: count holds P, state→IDLE.
- expire is registered, high exactly one cycle per completion, else 0.
- busy = (state==RUN or PAUSE), registered with state.
- Arithmetic: unsigned, WIDTH bits; count never exceeds P_latched, so no wrap beyond P. P=0: every tick expires.
- Input changes to period/prescale/mode during an interval have no effect until the next start.

## Timing
- Interval length = (P+1)·(S+1) clock cycles from the start edge to the edge asserting expire.
- Start sampled at edge N: busy=1 and count=0 after N. With S=0, count=k after edge N+k (k ≤ P), and expire is high after edge N+P+1.
- Auto-reload: expire pulses every (P+1)(S+1) cycles with no gap cycles; count returns to 0 on the same edge expire rises.
- One-shot: busy falls on the same edge expire rises; count holds P in IDLE until the next start/stop/reset.
- Pause for M cycles extends the interval by M+1 cycles: M frozen cycles plus the untick resume edge.
- start and stop on the same edge: stop wins → IDLE, count=0.
- Reset mid-interval: immediate return to reset values, no expire pulse.

## Test plan
- Reset during RUN (count=5): all outputs return to 0 asynchronously, before the next edge; expire stays 0.
- One-shot, P=3, S=0, start at edge 0: count 0,1,2,3 after edges 0–3; expire=1 and busy=0 after edge 4 only; count holds 3.
- Auto-reload, P=2, S=1: expire pulses every 6 cycles, 4 times in 24 cycles; expire_cnt=4. Run 17+ intervals: expire_cnt saturates at 15.
- Pause: P=4, S=0, pause held 3 cycles mid-interval: expire delayed 4 cycles vs. baseline (5→9 cycles); count frozen during PAUSE; busy stays 1.
- Restart/priority: start at count=2 → count=0, expire_cnt=0, new period latched; start+stop on same edge → IDLE, count=0, busy=0.
- P=0, S=0, mode 1: expire high every cycle after the start edge; count stays 0.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : interval_timer_ctrl
// Brief    : Programmable interval timer: prescaled up-counter with latched
//            terminal period, one-shot / auto-reload modes, pause, an expiry
//            pulse and a saturating expiry counter.
// Revision : 1.0 - initial release
// ============================================================================
module interval_timer_ctrl #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire,
    output logic [3:0]       expire_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [3:0] ECNT_MAX = 4'd15;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [PRE_W-1:0] pre_q,      pre_d;
    logic             expire_q,   expire_d;
    logic [3:0]       ecnt_q,     ecnt_d;
    logic             busy_q,     busy_d;
    logic             mode_q,     mode_d;
    logic [WIDTH-1:0] period_q,   period_d;
    logic [PRE_W-1:0] pres_q,     pres_d;

    // Next-state logic; control priority is stop, then start, then pause.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pre_d    = pre_q;
        expire_d = 1'b0;
        ecnt_d   = ecnt_q;
        mode_d   = mode_q;
        period_d = period_q;
        pres_d   = pres_q;

        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
            pre_d   = '0;
        end else if (start) begin
            mode_d   = mode;
            period_d = period;
            pres_d   = prescale;
            count_d  = '0;
            pre_d    = '0;
            ecnt_d   = '0;
            state_d  = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        // Entering PAUSE freezes everything; no tick this edge.
                        state_d = ST_PAUSE;
                    end else if (pre_q == pres_q) begin
                        pre_d = '0;
                        if (count_q != period_q) begin
                            count_d = count_q + 1'b1;
                        end else begin
                            expire_d = 1'b1;
                            if (ecnt_q != ECNT_MAX) begin
                                ecnt_d = ecnt_q + 1'b1;
                            end
                            if (mode_q) begin
                                count_d = '0;
                            end else begin
                                // One-shot leaves the terminal value visible.
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    // Resume edge does not tick either.
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            pre_q    <= '0;
            expire_q <= 1'b0;
            ecnt_q   <= '0;
            busy_q   <= 1'b0;
            mode_q   <= 1'b0;
            period_q <= '0;
            pres_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            expire_q <= expire_d;
            ecnt_q   <= ecnt_d;
            busy_q   <= busy_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            pres_q   <= pres_d;
        end
    end

    assign count      = count_q;
    assign busy       = busy_q;
    assign expire     = expire_q;
    assign expire_cnt = ecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_interval_timer_ctrl
// Brief    : Directed self-checking bench for interval_timer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interval_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] period = 8'd0;
    logic [3:0] prescale = 4'd0;
    logic [7:0] count;
    logic       busy;
    logic       expire;
    logic [3:0] expire_cnt;

    int n_cmp = 0;
    int n_err = 0;

    interval_timer_ctrl #(.WIDTH(8), .PRE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .mode       (mode),
        .period     (period),
        .prescale   (prescale),
        .count      (count),
        .busy       (busy),
        .expire     (expire),
        .expire_cnt (expire_cnt)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Drive a start for one rising edge; returns just after that edge.
    task automatic start_iv(input logic m, input logic [7:0] p, input logic [3:0] s);
        mode = m; period = p; prescale = s; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({count, busy, expire, expire_cnt} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_init: got count=%0d busy=%0b expire=%0b ecnt=%0d want all 0",
                     count, busy, expire, expire_cnt);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        start_iv(1'b0, 8'd3, 4'd0);
        n_cmp++;
        if (count !== 8'd0 || busy !== 1'b1 || expire !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_start: got count=%0d busy=%0b expire=%0b want 0 1 0", count, busy, expire);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++;
            if (count !== k[7:0] || busy !== 1'b1 || expire !== 1'b0) begin
                n_err++;
                $display("FAIL oneshot_count%0d: got count=%0d busy=%0b expire=%0b want %0d 1 0",
                         k, count, busy, expire, k);
            end
        end
        step();
        n_cmp++;
        if (count !== 8'd3 || busy !== 1'b0 || expire !== 1'b1 || expire_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL oneshot_expire: got count=%0d busy=%0b expire=%0b ecnt=%0d want 3 0 1 1",
                     count, busy, expire, expire_cnt);
        end
        step();
        n_cmp++;
        if (count !== 8'd3 || busy !== 1'b0 || expire !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_hold: got count=%0d busy=%0b expire=%0b want 3 0 0", count, busy, expire);
        end
    endtask

    task automatic test_autoreload();
        int errs;
        start_iv(1'b1, 8'd2, 4'd1);
        // Input changes after the start must be ignored.
        period = 8'd9; prescale = 4'd0; mode = 1'b0;
        errs = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (expire !== ((i % 6) == 0) || count !== 8'((i % 6) / 2) || busy !== 1'b1) begin
                errs++;
                $display("FAIL autoreload_cyc%0d: got expire=%0b count=%0d busy=%0b want %0b %0d 1",
                         i, expire, count, busy, ((i % 6) == 0), (i % 6) / 2);
            end
        end
        n_cmp++;
        if (errs != 0) n_err++;
        n_cmp++;
        if (expire_cnt !== 4'd4) begin
            n_err++;
            $display("FAIL autoreload_ecnt4: got %0d want 4", expire_cnt);
        end
        for (int i = 0; i < 13 * 6; i++) step();
        n_cmp++;
        if (expire_cnt !== 4'd15 || expire !== 1'b1) begin
            n_err++;
            $display("FAIL autoreload_sat: got ecnt=%0d expire=%0b want 15 1", expire_cnt, expire);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_cmp++;
        if (count !== 8'd0 || busy !== 1'b0 || expire_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL stop_hold_ecnt: got count=%0d busy=%0b ecnt=%0d want 0 0 15", count, busy, expire_cnt);
        end
    endtask

    task automatic test_pause();
        logic [7:0] exp_cnt [1:9];
        int errs;
        exp_cnt = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd4, 8'd4};
        start_iv(1'b0, 8'd4, 4'd0);
        errs = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (count !== exp_cnt[i] || expire !== (i == 9) || busy !== (i != 9)) begin
                errs++;
                $display("FAIL pause_cyc%0d: got count=%0d expire=%0b busy=%0b want %0d %0b %0b",
                         i, count, expire, busy, exp_cnt[i], (i == 9), (i != 9));
            end
            pause = (i >= 2 && i <= 4);
        end
        n_cmp++;
        if (errs != 0) n_err++;
    endtask

    task automatic test_restart();
        start_iv(1'b1, 8'd2, 4'd0);
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (count !== 8'd2 || expire_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL restart_pre: got count=%0d ecnt=%0d want 2 1", count, expire_cnt);
        end
        start_iv(1'b0, 8'd5, 4'd0);
        period = 8'd1;
        n_cmp++;
        if (count !== 8'd0 || expire_cnt !== 4'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart_clear: got count=%0d ecnt=%0d busy=%0b want 0 0 1", count, expire_cnt, busy);
        end
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (count !== 8'd5 || expire !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart_newp: got count=%0d expire=%0b busy=%0b want 5 0 1", count, expire, busy);
        end
        step();
        n_cmp++;
        if (expire !== 1'b1 || busy !== 1'b0 || expire_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL restart_expire: got expire=%0b busy=%0b ecnt=%0d want 1 0 1", expire, busy, expire_cnt);
        end
        // start+stop while idle: stop wins, so expire_cnt is not cleared.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        n_cmp++;
        if (count !== 8'd0 || busy !== 1'b0 || expire_cnt !== 4'd1 || expire !== 1'b0) begin
            n_err++;
            $display("FAIL startstop_idle: got count=%0d busy=%0b ecnt=%0d expire=%0b want 0 0 1 0",
                     count, busy, expire_cnt, expire);
        end
        // start+stop while running.
        start_iv(1'b0, 8'd9, 4'd0);
        step(); step();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        n_cmp++;
        if (count !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL startstop_run: got count=%0d busy=%0b want 0 0", count, busy);
        end
    endtask

    task automatic test_p0();
        start_iv(1'b1, 8'd0, 4'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++;
            if (expire !== 1'b1 || count !== 8'd0 || expire_cnt !== 4'(i) || busy !== 1'b1) begin
                n_err++;
                $display("FAIL p0_cyc%0d: got expire=%0b count=%0d ecnt=%0d busy=%0b want 1 0 %0d 1",
                         i, expire, count, expire_cnt, busy, i);
            end
        end
    endtask

    task automatic test_reset_midrun();
        start_iv(1'b1, 8'd5, 4'd0);
        for (int i = 0; i < 11; i++) step();
        n_cmp++;
        if (count !== 8'd5 || expire_cnt !== 4'd1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre: got count=%0d ecnt=%0d busy=%0b want 5 1 1", count, expire_cnt, busy);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({count, busy, expire, expire_cnt} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_async: got count=%0d busy=%0b expire=%0b ecnt=%0d want all 0",
                     count, busy, expire, expire_cnt);
        end
        step(); step();
        n_cmp++;
        if ({count, busy, expire, expire_cnt} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_hold: got count=%0d busy=%0b expire=%0b ecnt=%0d want all 0",
                     count, busy, expire, expire_cnt);
        end
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_restart();
        test_p0();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
